// File: rtl/rv32i_fetch_if.sv
// Fetch-stage channels: instruction-memory request/response and the decode-facing output.
interface rv32i_fetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst,
        output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready
    );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: credit-limited in-order memory requests, PC/response pairing
// and an output buffer toward decode; a redirect squashes everything older.

module rv32i_fetch_chk (
    input logic clk,
    input logic rst,
    input logic resp_valid_i,
    input logic idle_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);
    // Protocol checks: no response without an outstanding request, no buffer overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(resp_valid_i && idle_i));
            assert (!(push_i && !pop_i && full_i));
        end
    end
endmodule

module rv32i_fetch #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    rv32i_fetch_if.master bus
);
    localparam int TQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FQ_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0]      MAX_OUT_U = 32'(MAX_OUTSTANDING);
    localparam logic [31:0]      DEPTH_U   = 32'(FIFO_DEPTH);
    localparam logic [TQ_AW-1:0] TQ_LAST   = TQ_AW'(MAX_OUTSTANDING - 1);
    localparam logic [FQ_AW-1:0] FQ_LAST   = FQ_AW'(FIFO_DEPTH - 1);

    function automatic logic [TQ_AW-1:0] tq_next(input logic [TQ_AW-1:0] p);
        logic [TQ_AW-1:0] n;
        if (p == TQ_LAST) begin
            n = '0;
        end else begin
            n = p + TQ_AW'(1'b1);
        end
        return n;
    endfunction

    function automatic logic [FQ_AW-1:0] fq_next(input logic [FQ_AW-1:0] p);
        logic [FQ_AW-1:0] n;
        if (p == FQ_LAST) begin
            n = '0;
        end else begin
            n = p + FQ_AW'(1'b1);
        end
        return n;
    endfunction

    logic [31:0]                pc_q, pc_d;
    logic [IF_W-1:0]            inflight_q, inflight_d;
    logic [TQ_AW-1:0]           tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;
    logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;
    logic [31:0]                tag_pc_q [MAX_OUTSTANDING];
    logic [FQ_AW-1:0]           f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [FC_W-1:0]            f_cnt_q, f_cnt_d;
    logic [31:0]                fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]                fifo_inst_q [FIFO_DEPTH];

    logic credit_s, req_valid_s, req_fire_s, resp_fire_s, push_s, pop_s, out_valid_s;
    logic unused_lsb_s;

    assign unused_lsb_s = ^redirect_pc[1:0];

    // Handshake qualification; credit looks only at registered occupancy.
    always_comb begin
        credit_s    = (32'(inflight_q) < MAX_OUT_U) &&
                      ((32'(inflight_q) + 32'(f_cnt_q)) < DEPTH_U);
        req_valid_s = !rst && !redirect_valid && credit_s;
        req_fire_s  = req_valid_s && bus.mem_req_ready;
        resp_fire_s = bus.mem_resp_valid && (inflight_q != '0);
        out_valid_s = !rst && (f_cnt_q != '0);
        push_s      = resp_fire_s && !kill_q[tq_rd_q] && !redirect_valid;
        pop_s       = out_valid_s && bus.out_ready && !redirect_valid;
    end

    // PC, in-flight tag queue and kill marks.
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        kill_d     = kill_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (req_fire_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case ({req_fire_s, resp_fire_s})
            2'b10:   inflight_d = inflight_q + IF_W'(1'b1);
            2'b01:   inflight_d = inflight_q - IF_W'(1'b1);
            default: inflight_d = inflight_q;
        endcase

        if (req_fire_s) begin
            tq_wr_d = tq_next(tq_wr_q);
        end else begin
            tq_wr_d = tq_wr_q;
        end
        if (resp_fire_s) begin
            tq_rd_d = tq_next(tq_rd_q);
        end else begin
            tq_rd_d = tq_rd_q;
        end

        // Every outstanding tag (even one popped this cycle) belongs to the old path.
        if (redirect_valid) begin
            kill_d = '1;
        end else if (req_fire_s) begin
            kill_d[tq_wr_q] = 1'b0;
        end else begin
            kill_d = kill_q;
        end
    end

    // Output buffer pointers and occupancy; a redirect empties it outright.
    always_comb begin
        f_wr_d  = f_wr_q;
        f_rd_d  = f_rd_q;
        f_cnt_d = f_cnt_q;
        if (redirect_valid) begin
            f_wr_d  = '0;
            f_rd_d  = '0;
            f_cnt_d = '0;
        end else begin
            if (push_s) begin
                f_wr_d = fq_next(f_wr_q);
            end else begin
                f_wr_d = f_wr_q;
            end
            if (pop_s) begin
                f_rd_d = fq_next(f_rd_q);
            end else begin
                f_rd_d = f_rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   f_cnt_d = f_cnt_q + FC_W'(1'b1);
                2'b01:   f_cnt_d = f_cnt_q - FC_W'(1'b1);
                default: f_cnt_d = f_cnt_q;
            endcase
        end
    end

    // State registers; storage arrays need no reset because occupancy gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            inflight_q <= '0;
            tq_wr_q    <= '0;
            tq_rd_q    <= '0;
            kill_q     <= '0;
            f_wr_q     <= '0;
            f_rd_q     <= '0;
            f_cnt_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tq_wr_q    <= tq_wr_d;
            tq_rd_q    <= tq_rd_d;
            kill_q     <= kill_d;
            f_wr_q     <= f_wr_d;
            f_rd_q     <= f_rd_d;
            f_cnt_q    <= f_cnt_d;
            if (req_fire_s) begin
                tag_pc_q[tq_wr_q] <= pc_q;
            end
            if (push_s) begin
                fifo_pc_q[f_wr_q]   <= tag_pc_q[tq_rd_q];
                fifo_inst_q[f_wr_q] <= bus.mem_resp_data;
            end
        end
    end

    assign bus.mem_req_valid = req_valid_s;
    assign bus.mem_req_addr  = pc_q;
    assign bus.out_valid     = out_valid_s;
    assign bus.out_pc        = fifo_pc_q[f_rd_q];
    assign bus.out_inst      = fifo_inst_q[f_rd_q];

    rv32i_fetch_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .resp_valid_i (bus.mem_resp_valid),
        .idle_i       (inflight_q == '0),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .full_i       (32'(f_cnt_q) == DEPTH_U)
    );
endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed cycle table, back-to-back redirect sequence and
// randomized traffic checked against a queue-based reference model.
module tb_rv32i_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int MAXO  = 2;
    localparam int DEPTH = 2;
    localparam int NV    = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    rv32i_fetch_if bus();

    rv32i_fetch #(.RESET_ADDR(RST_PC), .MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic rst, rdv, rdy, rv, ordy, erv, ca, eov;
        logic [31:0] rdpc, raddr, eaddr, epc;
    } vec_t;
    typedef struct { logic [31:0] pc; logic kill; } tag_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    vec_t  vecs [NV];
    tag_t  tags[$];
    ent_t  fifo_m[$];
    mreq_t memq[$];
    logic [31:0] m_pc, path_next, last_deliv_pc;
    int cyc = 0;
    int delivered = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // f = {rst, redirect, req_ready, resp_valid, out_ready, exp_req_valid, exp_out_valid}
    function automatic vec_t mk(input logic [6:0] f, input logic [31:0] rdpc, raddr, eaddr, epc);
        vec_t v;
        {v.rst, v.rdv, v.rdy, v.rv, v.ordy, v.erv, v.eov} = f;
        v.rdpc = rdpc; v.raddr = raddr; v.eaddr = eaddr; v.epc = epc; v.ca = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cycle(input logic r, input logic rdv, input logic [31:0] rdpc,
                             input logic rdy, input logic ordy);
        logic resp, exp_rv, exp_ov;
        logic [31:0] raddr;
        tag_t t;
        resp  = 1'b0;
        raddr = 32'h0;
        if (!r && memq.size() != 0 && memq[0].due <= cyc && $urandom_range(3) != 0) begin
            resp  = 1'b1;
            raddr = memq[0].addr;
        end
        rst = r; redirect_valid = rdv; redirect_pc = rdpc;
        bus.mem_req_ready = rdy; bus.mem_resp_valid = resp;
        bus.mem_resp_data = inst_of(raddr); bus.out_ready = ordy;
        #1;
        exp_rv = !r && !rdv && (tags.size() < MAXO) && (tags.size() + fifo_m.size() < DEPTH);
        exp_ov = !r && (fifo_m.size() != 0);
        check("rnd.req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
        if (!r) check("rnd.req_addr", bus.mem_req_addr, m_pc);
        check("rnd.out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("rnd.out_pc", bus.out_pc, fifo_m[0].pc);
            check("rnd.out_inst", bus.out_inst, fifo_m[0].inst);
        end
        if (r) begin
            tags.delete(); fifo_m.delete(); memq.delete();
            m_pc = RST_PC; path_next = RST_PC;
        end else if (rdv) begin
            m_pc = {rdpc[31:2], 2'b00};
            path_next = m_pc;
            fifo_m.delete();
            if (resp) begin
                void'(tags.pop_front());
                void'(memq.pop_front());
            end
            foreach (tags[i]) tags[i].kill = 1'b1;
        end else begin
            if (exp_ov && ordy) begin
                check("rnd.path_pc", bus.out_pc, path_next);
                last_deliv_pc = bus.out_pc;
                path_next = path_next + 32'd4;
                delivered++;
                void'(fifo_m.pop_front());
            end
            if (resp) begin
                t = tags.pop_front();
                void'(memq.pop_front());
                if (!t.kill) fifo_m.push_back('{t.pc, inst_of(raddr)});
            end
            if (exp_rv && rdy) begin
                tags.push_back('{m_pc, 1'b0});
                memq.push_back('{m_pc, cyc + int'($urandom_range(3, 1))});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        vecs[0]  = mk(7'b1_0_1_0_1_0_0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[0].ca = 1'b0;
        vecs[1]  = mk(7'b1_0_1_0_1_0_0, 32'h0, 32'h0, 32'h100, 32'h0);
        vecs[2]  = mk(7'b0_0_1_0_1_1_0, 32'h0, 32'h0, 32'h100, 32'h0);
        vecs[3]  = mk(7'b0_0_1_1_1_1_0, 32'h0, 32'h100, 32'h104, 32'h0);
        vecs[4]  = mk(7'b0_0_1_1_1_0_1, 32'h0, 32'h104, 32'h108, 32'h100);
        vecs[5]  = mk(7'b0_0_1_0_1_1_1, 32'h0, 32'h0, 32'h108, 32'h104);
        vecs[6]  = mk(7'b0_0_1_1_1_1_0, 32'h0, 32'h108, 32'h10C, 32'h0);
        vecs[7]  = mk(7'b0_0_1_1_1_0_1, 32'h0, 32'h10C, 32'h110, 32'h108);
        vecs[8]  = mk(7'b0_0_1_0_1_1_1, 32'h0, 32'h0, 32'h110, 32'h10C);
        vecs[9]  = mk(7'b0_0_1_1_0_1_0, 32'h0, 32'h110, 32'h114, 32'h0);
        vecs[10] = mk(7'b0_0_1_1_0_0_1, 32'h0, 32'h114, 32'h118, 32'h110);
        vecs[11] = mk(7'b0_0_1_0_0_0_1, 32'h0, 32'h0, 32'h118, 32'h110);
        vecs[12] = mk(7'b0_0_1_0_0_0_1, 32'h0, 32'h0, 32'h118, 32'h110);
        vecs[13] = mk(7'b0_0_1_0_1_0_1, 32'h0, 32'h0, 32'h118, 32'h110);
        vecs[14] = mk(7'b0_0_1_0_1_1_1, 32'h0, 32'h0, 32'h118, 32'h114);
        vecs[15] = mk(7'b0_0_1_0_1_1_0, 32'h0, 32'h0, 32'h11C, 32'h0);
        vecs[16] = mk(7'b0_1_1_0_1_0_0, 32'h2003, 32'h0, 32'h120, 32'h0);
        vecs[17] = mk(7'b0_0_1_1_1_0_0, 32'h0, 32'h118, 32'h2000, 32'h0);
        vecs[18] = mk(7'b0_0_1_1_1_1_0, 32'h0, 32'h11C, 32'h2000, 32'h0);
        vecs[19] = mk(7'b0_0_1_1_1_1_0, 32'h0, 32'h2000, 32'h2004, 32'h0);
        vecs[20] = mk(7'b0_0_1_0_1_0_1, 32'h0, 32'h0, 32'h2008, 32'h2000);
        vecs[21] = mk(7'b0_0_0_1_1_1_0, 32'h0, 32'h2004, 32'h2008, 32'h0);
        vecs[22] = mk(7'b0_0_1_0_1_1_1, 32'h0, 32'h0, 32'h2008, 32'h2004);
        vecs[23] = mk(7'b0_0_1_1_0_1_0, 32'h0, 32'h2008, 32'h200C, 32'h0);
        vecs[24] = mk(7'b0_1_1_1_1_0_1, 32'hFFFF_FFF8, 32'h200C, 32'h2010, 32'h2008);
        vecs[25] = mk(7'b0_0_1_0_1_1_0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h0);
        vecs[26] = mk(7'b0_0_1_1_1_1_0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0);
        vecs[27] = mk(7'b0_0_1_1_1_0_1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFF8);
        vecs[28] = mk(7'b0_0_1_0_1_1_1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        vecs[29] = mk(7'b0_0_0_1_1_1_0, 32'h0, 32'h0, 32'h4, 32'h0);
        vecs[30] = mk(7'b0_0_0_0_1_1_1, 32'h0, 32'h0, 32'h4, 32'h0);
        vecs[31] = mk(7'b1_0_0_0_1_0_0, 32'h0, 32'h0, 32'h4, 32'h0);
        vecs[32] = mk(7'b0_0_0_0_1_1_0, 32'h0, 32'h0, 32'h100, 32'h0);

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; redirect_valid = vecs[i].rdv; redirect_pc = vecs[i].rdpc;
            bus.mem_req_ready = vecs[i].rdy; bus.mem_resp_valid = vecs[i].rv;
            bus.mem_resp_data = inst_of(vecs[i].raddr); bus.out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d.req_valid", i), 32'(bus.mem_req_valid), 32'(vecs[i].erv));
            if (vecs[i].ca) check($sformatf("vec%0d.req_addr", i), bus.mem_req_addr, vecs[i].eaddr);
            check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].eov));
            if (vecs[i].eov) begin
                check($sformatf("vec%0d.out_pc", i), bus.out_pc, vecs[i].epc);
                check($sformatf("vec%0d.out_inst", i), bus.out_inst, inst_of(vecs[i].epc));
            end
            @(posedge clk);
            #1;
        end

        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back redirects: only the second target survives.
        run_cycle(1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b1, 32'h0000_8001, 1'b1, 1'b1);
        d0 = delivered;
        for (int k = 0; k < 60 && delivered == d0; k++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("b2b.delivered", 32'(delivered != d0), 32'd1);
        check("b2b.first_pc", last_deliv_pc, 32'h0000_8000);

        for (int k = 0; k < 3000; k++) begin
            logic r_v, rdv_v, rdy_v, ordy_v;
            logic [31:0] rdpc_v;
            r_v    = ($urandom_range(499) == 0);
            rdv_v  = ($urandom_range(19) == 0);
            rdpc_v = $urandom;
            if ($urandom_range(3) == 0) rdpc_v = 32'hFFFF_FFF0 | (rdpc_v & 32'h0000_000F);
            rdy_v  = ($urandom_range(3) != 0);
            ordy_v = ($urandom_range(2) != 0);
            run_cycle(r_v, rdv_v, rdpc_v, rdy_v, ordy_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
